// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm - receive-side controller of the UART RX path.
// Oversamples RX_IN, majority-votes each bit, frames start/data/parity/stop
// bits, deserializes data LSB-first and drives an external parity checker.
// Optional build macro: UART_RX_ERR_CNT_EN adds the saturating err_cnt output.
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  PAR_EN,
   input  logic                  par_err,
   output logic                  sampled_bit,
   output logic                  parity_check_en,
   output logic [DATA_WIDTH-1:0] P_data,
   output logic                  data_valid,
   output logic                  par_err_o,
   output logic                  stop_err,
   output logic                  strt_glitch
`ifdef UART_RX_ERR_CNT_EN
   ,
   output logic [7:0]            err_cnt
`endif
);

   localparam int BCNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [PRESCALE_W-1:0] ps_r, ps_sel_s, half_s, edge_cnt_r;
   logic                  par_en_r;
   logic [BCNT_W-1:0]     bit_cnt_r;
   logic [DATA_WIDTH-1:0] shift_r, pdata_r;
   logic                  perr_r;
   logic                  smp_lo_r, smp_mid_r, sampled_bit_r;
   logic                  pce_r;
   logic                  data_valid_r, par_err_o_r, stop_err_r, strt_glitch_r;
   logic                  eval_s, last_bit_s;
   logic                  valid_nxt_s, perr_o_nxt_s, stop_err_nxt_s, glitch_nxt_s;

   // 2-of-3 majority used to vote the three mid-bit samples
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign half_s     = {1'b0, ps_r[PRESCALE_W-1:1]};
   assign eval_s     = (edge_cnt_r == (ps_r - PRESCALE_W'(1)));
   assign last_bit_s = (bit_cnt_r == BCNT_W'(DATA_WIDTH - 1));

   // Legalise the requested oversampling ratio; anything unsupported runs at 8
   always_comb begin
      ps_sel_s = PRESCALE_W'(8);
      if ((prescale == PRESCALE_W'(16)) || (prescale == PRESCALE_W'(32))) begin
         ps_sel_s = prescale;
      end else begin
         ps_sel_s = PRESCALE_W'(8);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state and end-of-frame pulse decisions
   always_comb begin
      state_nxt_s    = state_r;
      valid_nxt_s    = 1'b0;
      perr_o_nxt_s   = 1'b0;
      stop_err_nxt_s = 1'b0;
      glitch_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!RX_IN) begin
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (eval_s) begin
               if (sampled_bit_r) begin
                  glitch_nxt_s = 1'b1;
                  state_nxt_s  = IDLE;
               end else begin
                  state_nxt_s  = DATA;
               end
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            if (eval_s && last_bit_s) begin
               if (par_en_r) begin
                  state_nxt_s = PARITY;
               end else begin
                  state_nxt_s = STOP;
               end
            end else begin
               state_nxt_s = DATA;
            end
         end
         PARITY: begin
            if (eval_s) begin
               state_nxt_s = STOP;
            end else begin
               state_nxt_s = PARITY;
            end
         end
         STOP: begin
            if (eval_s) begin
               state_nxt_s = IDLE;
               if (!sampled_bit_r) begin
                  stop_err_nxt_s = 1'b1;
               end else if (perr_r) begin
                  perr_o_nxt_s = 1'b1;
               end else begin
                  valid_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Latch frame configuration at start detection; ignore later changes
   always_ff @(posedge clk) begin
      if (!rst) begin
         ps_r     <= PRESCALE_W'(8);
         par_en_r <= 1'b0;
      end else if ((state_r == IDLE) && !RX_IN) begin
         ps_r     <= ps_sel_s;
         par_en_r <= PAR_EN;
      end
   end

   // Oversampling edge counter, 0..ps-1 within each bit
   always_ff @(posedge clk) begin
      if (!rst) begin
         edge_cnt_r <= {PRESCALE_W{1'b0}};
      end else if ((state_r == IDLE) || eval_s) begin
         edge_cnt_r <= {PRESCALE_W{1'b0}};
      end else begin
         edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
      end
   end

   // Capture three mid-bit samples; the vote becomes visible at edge ps/2+2
   always_ff @(posedge clk) begin
      if (!rst) begin
         smp_lo_r      <= 1'b0;
         smp_mid_r     <= 1'b0;
         sampled_bit_r <= 1'b0;
      end else if (state_r != IDLE) begin
         if (edge_cnt_r == (half_s - PRESCALE_W'(1))) begin
            smp_lo_r <= RX_IN;
         end
         if (edge_cnt_r == half_s) begin
            smp_mid_r <= RX_IN;
         end
         if (edge_cnt_r == (half_s + PRESCALE_W'(1))) begin
            sampled_bit_r <= maj3(smp_lo_r, smp_mid_r, RX_IN);
         end
      end
   end

   // Deserialise data bits LSB-first and count them
   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_cnt_r <= {BCNT_W{1'b0}};
         shift_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            START: begin
               bit_cnt_r <= {BCNT_W{1'b0}};
            end
            DATA: begin
               if (eval_s) begin
                  shift_r   <= {sampled_bit_r, shift_r[DATA_WIDTH-1:1]};
                  bit_cnt_r <= bit_cnt_r + BCNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Hold the checker's verdict for this frame; forget it between frames
   always_ff @(posedge clk) begin
      if (!rst) begin
         perr_r <= 1'b0;
      end else if (state_r == IDLE) begin
         perr_r <= 1'b0;
      end else if ((state_r == PARITY) && eval_s) begin
         perr_r <= par_err;
      end
   end

   // One-cycle checker strobe at edge ps-2 of the parity bit
   always_ff @(posedge clk) begin
      if (!rst) begin
         pce_r <= 1'b0;
      end else begin
         pce_r <= (state_r == PARITY) && (edge_cnt_r == (ps_r - PRESCALE_W'(3)));
      end
   end

   // Registered result pulses and the held output word
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_valid_r  <= 1'b0;
         par_err_o_r   <= 1'b0;
         stop_err_r    <= 1'b0;
         strt_glitch_r <= 1'b0;
         pdata_r       <= {DATA_WIDTH{1'b0}};
      end else begin
         data_valid_r  <= valid_nxt_s;
         par_err_o_r   <= perr_o_nxt_s;
         stop_err_r    <= stop_err_nxt_s;
         strt_glitch_r <= glitch_nxt_s;
         if (valid_nxt_s) begin
            pdata_r <= shift_r;
         end
      end
   end

`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] err_cnt_r;

   // Saturating count of rejected frames and start glitches
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_cnt_r <= 8'd0;
      end else if ((glitch_nxt_s || stop_err_nxt_s || perr_o_nxt_s) && (err_cnt_r != 8'd255)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end
   end

   assign err_cnt = err_cnt_r;
`endif

   // The checker sees the shift register only during its strobe cycle
   assign P_data          = pce_r ? shift_r : pdata_r;
   assign sampled_bit     = sampled_bit_r;
   assign parity_check_en = pce_r;
   assign data_valid      = data_valid_r;
   assign par_err_o       = par_err_o_r;
   assign stop_err        = stop_err_r;
   assign strt_glitch     = strt_glitch_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: a scoreboard of expected output
// events (kind, cycle, P_data) filled as frames are driven and drained by
// a negedge monitor; includes an even-parity checker model.
module tb_uart_rx_fsm;
   localparam int DW = 8;
   localparam int PW = 6;
   localparam int K_DV = 0, K_PERR = 1, K_STOP = 2, K_GLITCH = 3, K_PCE = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          RX_IN = 1'b1;
   logic [PW-1:0] prescale = 6'd8;
   logic          PAR_EN = 1'b0;
   logic          par_err;
   logic          sampled_bit, parity_check_en, data_valid, par_err_o, stop_err, strt_glitch;
   logic [DW-1:0] P_data;
   logic [4:0]    pulse_vec;
`ifdef UART_RX_ERR_CNT_EN
   logic [7:0]    err_cnt;
   int            err_exp = 0;
`endif

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   logic [7:0] pdata_exp = 8'h00;

   uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
      .clk(clk), .rst(rst), .RX_IN(RX_IN), .prescale(prescale), .PAR_EN(PAR_EN),
      .par_err(par_err), .sampled_bit(sampled_bit), .parity_check_en(parity_check_en),
      .P_data(P_data), .data_valid(data_valid), .par_err_o(par_err_o),
      .stop_err(stop_err), .strt_glitch(strt_glitch)
`ifdef UART_RX_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Cycle counter used to timestamp events
   always @(posedge clk) cyc <= cyc + 1;

   // Even-parity checker model with a registered error output
   always @(posedge clk) begin
      if (!rst) par_err <= 1'b0;
      else if (parity_check_en) par_err <= (^P_data) ^ sampled_bit;
   end

   assign pulse_vec = {parity_check_en, strt_glitch, stop_err, par_err_o, data_valid};

   // Scoreboard monitor: every pulse must match the next expected event
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 5; k++) begin
            if (pulse_vec[k] === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected kind=%0d cyc=%0d data=%h expected no event", k, cyc, P_data);
               end else begin
                  e = exp_q.pop_front();
                  if (e.kind !== k || e.cyc !== cyc || e.data !== P_data) begin
                     errors++;
                     $display("FAIL sb_event got kind=%0d cyc=%0d data=%h expected kind=%0d cyc=%0d data=%h",
                              k, cyc, P_data, e.kind, e.cyc, e.data);
                  end
               end
            end
         end
      end
   end

   task automatic drive_bit(input int ps, input logic b, input logic flip);
      for (int c = 0; c < ps; c++) begin
         // offset 5 on the line is DUT edge 4 (DUT lags the line by one cycle)
         RX_IN = (flip && c == 5) ? ~b : b;
         @(posedge clk); #1;
      end
   endtask

   // Drive one frame starting this cycle; config pins are disturbed after the start bit
   task automatic send_frame(input logic [PW-1:0] ps_pin, input int ps, input logic pe,
                             input logic [7:0] d, input logic pbit, input logic stopb,
                             input logic flip);
      prescale = ps_pin;
      PAR_EN   = pe;
      drive_bit(ps, 1'b0, 1'b0);
      prescale = (ps_pin == 6'd32) ? 6'd8 : 6'd32;
      PAR_EN   = ~pe;
      for (int i = 0; i < DW; i++) drive_bit(ps, d[i], flip);
      if (pe) drive_bit(ps, pbit, 1'b0);
      drive_bit(ps, stopb, 1'b0);
      RX_IN = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({sampled_bit, parity_check_en, data_valid, par_err_o, stop_err, strt_glitch} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b expected 000000",
                  {sampled_bit, parity_check_en, data_valid, par_err_o, stop_err, strt_glitch});
      end
      checks++;
      if (P_data !== 8'h00) begin errors++; $display("FAIL reset_pdata got %h expected 00", P_data); end
`ifdef UART_RX_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d expected 0", err_cnt); end
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic test_no_parity();
      int fs;
      @(posedge clk); #1;
      fs = cyc + 1;
      exp_q.push_back('{K_DV, fs + 80, 8'hA5});
      pdata_exp = 8'hA5;
      send_frame(6'd8, 8, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL no_parity_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_parity(input logic pbit);
      int fs;
      @(posedge clk); #1;
      fs = cyc + 1;
      exp_q.push_back('{K_PCE, fs + 9 * 16 + 14, 8'h3C});
      if (pbit) begin
         exp_q.push_back('{K_PERR, fs + 176, pdata_exp});
`ifdef UART_RX_ERR_CNT_EN
         err_exp++;
`endif
      end else begin
         exp_q.push_back('{K_DV, fs + 176, 8'h3C});
         pdata_exp = 8'h3C;
      end
      send_frame(6'd16, 16, 1'b1, 8'h3C, pbit, 1'b1, 1'b0);
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL parity%0d_drain pending=%0d expected 0", pbit, exp_q.size()); exp_q.delete(); end
`ifdef UART_RX_ERR_CNT_EN
      checks++;
      if (err_cnt !== err_exp[7:0]) begin errors++; $display("FAIL parity_errcnt got %0d expected %0d", err_cnt, err_exp); end
`endif
   endtask

   task automatic test_start_glitch();
      int fs;
      @(posedge clk); #1;
      prescale = 6'd8;
      fs = cyc + 1;
      exp_q.push_back('{K_GLITCH, fs + 8, pdata_exp});
`ifdef UART_RX_ERR_CNT_EN
      err_exp++;
`endif
      RX_IN = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      RX_IN = 1'b1;
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
`ifdef UART_RX_ERR_CNT_EN
      checks++;
      if (err_cnt !== err_exp[7:0]) begin errors++; $display("FAIL glitch_errcnt got %0d expected %0d", err_cnt, err_exp); end
`endif
      repeat (10) begin @(posedge clk); #1; end
   endtask

   task automatic test_stop_err_reset();
      int fs;
      @(posedge clk); #1;
      fs = cyc + 1;
      exp_q.push_back('{K_STOP, fs + 320, pdata_exp});
`ifdef UART_RX_ERR_CNT_EN
      err_exp++;
`endif
      send_frame(6'd32, 32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL stop_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
`ifdef UART_RX_ERR_CNT_EN
      checks++;
      if (err_cnt !== err_exp[7:0]) begin errors++; $display("FAIL stop_errcnt got %0d expected %0d", err_cnt, err_exp); end
`endif
      // start another frame and pull reset for one cycle in its start bit
      @(posedge clk); #1;
      prescale = 6'd32;
      RX_IN = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      RX_IN = 1'b1;
      pdata_exp = 8'h00;
      @(negedge clk);
      checks++;
      if ({parity_check_en, data_valid, par_err_o, stop_err, strt_glitch} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_flags got %b expected 00000",
                  {parity_check_en, data_valid, par_err_o, stop_err, strt_glitch});
      end
      checks++;
      if (P_data !== 8'h00) begin errors++; $display("FAIL midreset_pdata got %h expected 00", P_data); end
`ifdef UART_RX_ERR_CNT_EN
      err_exp = 0;
      checks++;
      if (err_cnt !== 8'd0) begin errors++; $display("FAIL midreset_errcnt got %0d expected 0", err_cnt); end
`endif
      // an aborted frame must leave no pulse behind (monitor flags any)
      repeat (400) begin @(posedge clk); #1; end
   endtask

   task automatic test_majority();
      int fs;
      @(posedge clk); #1;
      fs = cyc + 1;
      exp_q.push_back('{K_DV, fs + 80, 8'h5A});
      pdata_exp = 8'h5A;
      send_frame(6'd8, 8, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL majority_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_back_to_back();
      int fs1, fs2;
      @(posedge clk); #1;
      fs1 = cyc + 1;
      exp_q.push_back('{K_DV, fs1 + 80, 8'h01});
      send_frame(6'd8, 8, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
      // next start bit goes on the line in frame 1's pulse cycle
      @(posedge clk); #1;
      fs2 = cyc + 1;
      checks++;
      if (fs2 - 1 != fs1 + 80) begin errors++; $display("FAIL b2b_align got %0d expected %0d", fs2 - 1, fs1 + 80); end
      exp_q.push_back('{K_DV, fs2 + 80, 8'h80});
      pdata_exp = 8'h80;
      // illegal prescale 7 must run as 8
      send_frame(6'd7, 8, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
      checks++;
      if (P_data !== 8'h80) begin errors++; $display("FAIL b2b_pdata got %h expected 80", P_data); end
   endtask

   initial begin
      test_reset();
      test_no_parity();
      test_parity(1'b1);
      test_parity(1'b0);
      test_start_glitch();
      test_stop_err_reset();
      test_majority();
      test_back_to_back();
      repeat (20) begin @(posedge clk); #1; end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
